// File: rtl/demux4_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux4_stream
// Brief    : Packet-locking 1-to-4 stream demux with a FIFO on each output.
// Revision : 1.0 - initial release
// ============================================================================
module demux4_stream #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_d,
    input  logic [1:0]       in_s,
    input  logic             in_last,
    output logic [WIDTH-1:0] out_d0,
    output logic [WIDTH-1:0] out_d1,
    output logic [WIDTH-1:0] out_d2,
    output logic [WIDTH-1:0] out_d3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       lock_s_q;
    logic [1:0]       lock_s_d;
    logic [1:0]       ch;
    logic             accept;
    logic [3:0]       full;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [WIDTH-1:0] head [4];

    // Once a packet is open its remaining beats follow the first beat's select.
    assign ch       = (state_q == LOCKED) ? lock_s_q : in_s;
    assign in_ready = ~full[ch];
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q == LOCKED);

    always_comb begin
        state_d  = state_q;
        lock_s_d = lock_s_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (!in_last) begin
                        state_d  = LOCKED;
                        lock_s_d = in_s;
                    end
                end
                LOCKED: begin
                    if (in_last) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lock_s_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            lock_s_q <= lock_s_d;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_chan
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [WIDTH-1:0] mem_d [DEPTH];
        logic [AW-1:0]    wr_ptr_q;
        logic [AW-1:0]    wr_ptr_d;
        logic [AW-1:0]    rd_ptr_q;
        logic [AW-1:0]    rd_ptr_d;
        logic [CW-1:0]    cnt_q;
        logic [CW-1:0]    cnt_d;

        // A full FIFO refuses the push even if it pops in the same cycle.
        assign full[k]      = (cnt_q == CNT_FULL);
        assign out_valid[k] = (cnt_q != '0);
        assign push[k]      = accept && (ch == 2'(k));
        assign pop[k]       = out_valid[k] & out_ready[k];
        assign head[k]      = out_valid[k] ? mem_q[rd_ptr_q] : '0;

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push[k]) begin
                mem_d[wr_ptr_q] = in_d;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop[k]) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push[k] && !pop[k]) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (!push[k] && pop[k]) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage needs no reset: the head is masked to zero while empty.
        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end
    end

    assign out_d0 = head[0];
    assign out_d1 = head[1];
    assign out_d2 = head[2];
    assign out_d3 = head[3];

endmodule
`default_nettype wire

// File: tb/tb_demux4_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux4_stream
// Brief    : Scoreboard bench for demux4_stream with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux4_stream;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_d = '0;
    logic [1:0]       in_s = 2'd0;
    logic             in_last = 1'b0;
    logic [WIDTH-1:0] out_d0, out_d1, out_d2, out_d3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready = 4'd0;
    logic             busy;

    demux4_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d      (in_d),
        .in_s      (in_s),
        .in_last   (in_last),
        .out_d0    (out_d0),
        .out_d1    (out_d1),
        .out_d2    (out_d2),
        .out_d3    (out_d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: one queue of pending beats per channel plus packet lock.
    logic [WIDTH-1:0] exp_q [4][$];
    int               popped [4];
    bit               m_locked = 1'b0;
    logic [1:0]       m_lock = 2'd0;
    bit               mon_en = 1'b0;
    int               n_tests = 0;
    int               n_fail = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s ch%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] dout(input int k);
        case (k)
            0:       return out_d0;
            1:       return out_d1;
            2:       return out_d2;
            default: return out_d3;
        endcase
    endfunction

    // Monitor: compares what the DUT presents and retires beats it hands over.
    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                logic             ev;
                logic [WIDTH-1:0] ed;
                ev = (exp_q[k].size() != 0);
                ed = ev ? exp_q[k][0] : '0;
                chk("out_valid", k, 32'(out_valid[k]), 32'(ev));
                chk("out_d", k, 32'(dout(k)), 32'(ed));
                popped[k] = (reset_n && ev && out_ready[k]) ? 1 : 0;
                if (popped[k] != 0) begin
                    void'(exp_q[k].pop_front());
                end
            end
            chk("busy", 0, 32'(busy), 32'(m_locked));
        end else begin
            for (int k = 0; k < 4; k++) popped[k] = 0;
        end
    end

    // One clock of stimulus; acceptance is decided by the model, not the DUT.
    task automatic cycle(input logic rn, input logic v, input logic [1:0] s,
                         input logic [WIDTH-1:0] d, input logic l, input logic [3:0] ordy);
        int         occ;
        logic [1:0] ch;
        logic       exp_rdy;
        @(negedge clk);
        reset_n   = rn;
        in_valid  = v;
        in_s      = s;
        in_d      = d;
        in_last   = l;
        out_ready = ordy;
        #2;
        if (!rn) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
            m_locked = 1'b0;
            m_lock   = 2'd0;
        end else begin
            ch      = m_locked ? m_lock : s;
            occ     = exp_q[ch].size() + popped[ch];
            exp_rdy = (occ < DEPTH);
            chk("in_ready", int'(ch), 32'(in_ready), 32'(exp_rdy));
            if (v && exp_rdy) begin
                exp_q[ch].push_back(d);
                if (!m_locked && !l) begin
                    m_locked = 1'b1;
                    m_lock   = s;
                end else if (m_locked && l) begin
                    m_locked = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic [3:0] ordy);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'd0, '0, 1'b0, ordy);
    endtask

    initial begin
        cycle(1'b0, 1'b1, 2'd1, 4'h5, 1'b0, 4'hF);
        cycle(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0);
        mon_en = 1'b1;
        // Every select is ready out of reset.
        for (int s = 0; s < 4; s++) cycle(1'b1, 1'b0, 2'(s), '0, 1'b0, 4'h0);

        // Single beat to channel 2, held by its consumer.
        cycle(1'b1, 1'b1, 2'd2, 4'hA, 1'b1, 4'h0);
        idle(2, 4'h0);
        idle(2, 4'hF);

        // Locked packet: later selects are ignored until the last beat.
        cycle(1'b1, 1'b1, 2'd1, 4'h3, 1'b0, 4'h0);
        cycle(1'b1, 1'b1, 2'd3, 4'h4, 1'b0, 4'h0);
        cycle(1'b1, 1'b1, 2'd0, 4'h5, 1'b1, 4'h0);
        cycle(1'b1, 1'b1, 2'd0, 4'h5, 1'b1, 4'h2);
        idle(4, 4'hF);

        // Fill channel 0, probe readiness, then release one entry.
        cycle(1'b1, 1'b1, 2'd0, 4'h1, 1'b1, 4'h0);
        cycle(1'b1, 1'b1, 2'd0, 4'h2, 1'b1, 4'h0);
        cycle(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0);
        cycle(1'b1, 1'b0, 2'd1, 4'h0, 1'b1, 4'h0);
        cycle(1'b1, 1'b1, 2'd0, 4'h9, 1'b1, 4'h1);
        cycle(1'b1, 1'b0, 2'd0, 4'h0, 1'b1, 4'h0);
        idle(3, 4'hF);

        // Push and pop together on a one-entry channel 3.
        cycle(1'b1, 1'b1, 2'd3, 4'h7, 1'b1, 4'h0);
        cycle(1'b1, 1'b1, 2'd3, 4'h8, 1'b1, 4'h8);
        idle(2, 4'h0);
        idle(2, 4'hF);

        // Reset in the middle of a packet with data buffered.
        cycle(1'b1, 1'b1, 2'd2, 4'hC, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 2'd2, 4'hD, 1'b0, 4'h0);
        cycle(1'b1, 1'b1, 2'd0, 4'hE, 1'b1, 4'h0);
        idle(2, 4'hF);

        // Randomized traffic with occasional stalls and resets.
        for (int i = 0; i < 4000; i++) begin
            logic rn;
            logic [3:0] ordy;
            rn   = ($urandom_range(0, 299) != 0);
            ordy = 4'($urandom) & 4'($urandom | $urandom);
            if ((i / 200) % 2 == 1) ordy[(i / 400) % 4] = 1'b0;
            cycle(rn, ($urandom_range(0, 9) < 7), 2'($urandom), 4'($urandom),
                  ($urandom_range(0, 2) == 0), ordy);
        end
        idle(8, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux4_stream.md
DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter WIDTH, default 4: data width of the input and of each output channel.
REQ-003 Parameter DEPTH, default 2: entries per output FIFO; power of two, at least 2.
REQ-004 Port clk  input  1: rising-edge clock for all state.
REQ-005 Port reset_n  input  1: synchronous active-low reset.
REQ-006 Port in_valid  input  1: input beat is present.
REQ-007 Port in_ready  output  1: block accepts the input beat this cycle.
REQ-008 Port in_d  input  WIDTH: input data.
REQ-009 Port in_s  input  2: destination channel select, 0..3.
REQ-010 Port in_last  input  1: final beat of a packet.
REQ-011 Ports out_d0, out_d1, out_d2, out_d3  output  WIDTH each: head data of channel 0..3.
REQ-012 Port out_valid  output  4: bit k is high when channel k FIFO is non-empty.
REQ-013 Port out_ready  input  4: bit k means the channel k consumer takes the head this cycle.
REQ-014 Port busy  output  1: high while a multi-beat packet is locked (state LOCKED).

Function
REQ-015 Input handshake: a beat SHALL be accepted on a rising edge when in_valid and in_ready are both high.
REQ-016 Output handshake: a channel k beat SHALL be consumed on a rising edge when out_valid[k] and out_ready[k] are both high.
REQ-017 FSM states SHALL be IDLE and LOCKED; reset state is IDLE.
REQ-018 Effective channel ch SHALL be in_s in IDLE, and lock_s (registered) in LOCKED; in_s is ignored in LOCKED.
REQ-019 IDLE to LOCKED: on acceptance with in_last=0, lock_s <= in_s.
REQ-020 IDLE, acceptance with in_last=1: single-beat packet; stay IDLE.
REQ-021 LOCKED to IDLE: on acceptance with in_last=1.
REQ-022 No acceptance: state and lock_s hold.
REQ-023 in_ready SHALL be the combinational value NOT full(ch); it does not depend on in_valid or out_ready.
REQ-024 Full FIFO: no push even when the same FIFO pops in that cycle; no pass-through.
REQ-025 Accepted beat SHALL be written into FIFO ch only; the other channels are unchanged.
REQ-026 Latency: a beat accepted at edge N SHALL make out_valid[ch]=1 with the beat on out_d<ch> after edge N.
REQ-027 Each FIFO SHALL be first-in first-out and may push and pop in the same cycle.
REQ-028 Simultaneous push and pop when not full: occupancy SHALL be unchanged, and order SHALL be preserved.
REQ-029 Pop on an empty FIFO SHALL have no effect.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 Full/empty SHALL be distinguished by an occupancy counter of width log2(DEPTH)+1.
REQ-032 out_d<k> SHALL present the head entry whenever out_valid[k]=1.
REQ-033 out_d<k> SHALL be 0 while FIFO k is empty.
REQ-034 busy SHALL equal (state == LOCKED), registered.
REQ-035 Four independent channels SHALL drain concurrently.
REQ-036 A stalled channel SHALL block input only while it is the effective ch.

Reset
REQ-037 While reset_n=0 at a rising edge, the next state SHALL be: state IDLE, lock_s 0, all FIFO pointers and counters 0.
REQ-038 After reset, outputs SHALL be: out_valid 4'b0000, out_d0..3 all 0, busy 0.
REQ-039 After reset, in_ready SHALL be 1 for any in_s.
REQ-040 Reset mid-packet or with data buffered SHALL discard all buffered beats and the lock; nothing is emitted afterward.
REQ-041 in_valid is don't-care during reset; no beat is accepted while reset_n=0.

Verification
REQ-042 Single beat: in_s=2, in_d=4'hA, in_last=1, out_ready=0 -> next cycle out_valid=4'b0100, out_d2=4'hA, busy=0.
REQ-043 Lock: beat1 s=1,last=0 (d=3); beat2 s=3,last=0 (d=4); beat3 s=0,last=1 (d=5) -> all three land on ch1 in order 3,4,5; busy high after beat1 until after beat3.
REQ-044 Full: DEPTH=2, ch0 with out_ready[0]=0, push d=1,2 -> in_ready=0 for s=0 and 1 for s=1; assert out_ready[0] one cycle -> d=1 popped, in_ready returns to 1 the next cycle.
REQ-045 Concurrent push/pop: ch3 holds one entry (d=7); push d=8 while popping -> out_d3=8 next cycle, occupancy stays 1.
REQ-046 Reset mid-packet: after beat1 s=2,last=0 is accepted, pulse reset_n=0 for one edge -> out_valid=0, busy=0; next beat with s=0,last=1 goes to ch0.
